// File: rtl/cpu_mem_if.sv
// Data-bus port of the memory stage: one outstanding word access, req held until a one-cycle ack.
interface cpu_mem_if;
    logic        d_req;
    logic        d_rw;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;

    modport master (output d_req, d_rw, d_addr, d_wdata, input d_rdata, d_ack);
    modport slave  (input d_req, d_rw, d_addr, d_wdata, output d_rdata, d_ack);
endinterface

// File: rtl/cpu_mem.sv
// Memory-access pipeline stage: word loads/stores over the req/ack bus, upstream stall while
// an access is outstanding, misalignment and bus-timeout faults, registered write-back controls.
module cpu_mem #(
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_c_rfw,
    input  logic [1:0]       ex_c_wbsource,
    input  logic             ex_c_drw,
    input  logic [31:0]      ex_alu_r,
    input  logic [31:0]      ex_rfb,
    input  logic [4:0]       ex_rf_waddr,
    input  logic [31:0]      ex_jalra,
    cpu_mem_if.master        dbus,
    output logic             stall,
    output logic             p_c_rfw,
    output logic [4:0]       p_rf_waddr,
    output logic [31:0]      p_wb_data,
    output logic             p_err,
    output logic [31:0]      p_err_addr
);
    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        d_req_q, d_req_d;
    logic        d_rw_q, d_rw_d;
    logic [31:0] d_addr_q, d_addr_d;
    logic [31:0] d_wdata_q, d_wdata_d;
    logic        p_c_rfw_q, p_c_rfw_d;
    logic [4:0]  p_rf_waddr_q, p_rf_waddr_d;
    logic [31:0] p_wb_data_q, p_wb_data_d;
    logic        p_err_q, p_err_d;
    logic [31:0] p_err_addr_q, p_err_addr_d;

    logic memop, aligned, cnt_last;

    assign memop    = ex_c_drw | (ex_c_wbsource == 2'd1);
    assign aligned  = (ex_alu_r[1:0] == 2'b00);
    assign cnt_last = (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            d_req_q      <= 1'b0;
            d_rw_q       <= 1'b0;
            d_addr_q     <= '0;
            d_wdata_q    <= '0;
            p_c_rfw_q    <= 1'b0;
            p_rf_waddr_q <= '0;
            p_wb_data_q  <= '0;
            p_err_q      <= 1'b0;
            p_err_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            d_req_q      <= d_req_d;
            d_rw_q       <= d_rw_d;
            d_addr_q     <= d_addr_d;
            d_wdata_q    <= d_wdata_d;
            p_c_rfw_q    <= p_c_rfw_d;
            p_rf_waddr_q <= p_rf_waddr_d;
            p_wb_data_q  <= p_wb_data_d;
            p_err_q      <= p_err_d;
            p_err_addr_q <= p_err_addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (memop && aligned) state_d = S_WAIT;
            S_WAIT:  if (dbus.d_ack || cnt_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Write-back controls default to a bubble; only a plain op or a load ack writes the RF.
    always_comb begin
        stall        = 1'b0;
        cnt_d        = cnt_q;
        d_req_d      = d_req_q;
        d_rw_d       = d_rw_q;
        d_addr_d     = d_addr_q;
        d_wdata_d    = d_wdata_q;
        p_c_rfw_d    = 1'b0;
        p_rf_waddr_d = p_rf_waddr_q;
        p_wb_data_d  = p_wb_data_q;
        p_err_d      = 1'b0;
        p_err_addr_d = p_err_addr_q;
        case (state_q)
            S_IDLE: begin
                if (!memop) begin
                    p_c_rfw_d    = ex_c_rfw;
                    p_rf_waddr_d = ex_rf_waddr;
                    case (ex_c_wbsource)
                        2'd0:    p_wb_data_d = ex_alu_r;
                        2'd2:    p_wb_data_d = ex_jalra;
                        default: p_wb_data_d = 32'd0;
                    endcase
                end else if (!aligned) begin
                    p_err_d      = 1'b1;
                    p_err_addr_d = ex_alu_r;
                end else begin
                    stall     = 1'b1;
                    d_req_d   = 1'b1;
                    d_rw_d    = ex_c_drw;
                    d_addr_d  = ex_alu_r;
                    d_wdata_d = ex_rfb;
                    cnt_d     = '0;
                end
            end
            S_WAIT: begin
                stall = !dbus.d_ack && !cnt_last;
                // An ack landing on the last permitted cycle still completes the access.
                if (dbus.d_ack) begin
                    d_req_d = 1'b0;
                    if (!d_rw_q) begin
                        p_wb_data_d  = dbus.d_rdata;
                        p_c_rfw_d    = ex_c_rfw;
                        p_rf_waddr_d = ex_rf_waddr;
                    end
                end else if (cnt_last) begin
                    d_req_d      = 1'b0;
                    p_err_d      = 1'b1;
                    p_err_addr_d = d_addr_q;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    assign dbus.d_req    = d_req_q;
    assign dbus.d_rw     = d_rw_q;
    assign dbus.d_addr   = d_addr_q;
    assign dbus.d_wdata  = d_wdata_q;
    assign p_c_rfw       = p_c_rfw_q;
    assign p_rf_waddr    = p_rf_waddr_q;
    assign p_wb_data     = p_wb_data_q;
    assign p_err         = p_err_q;
    assign p_err_addr    = p_err_addr_q;
endmodule
